// File: rtl/ram_2p_boot.sv
// True-dual-port RAM: port A is shared between the CPU instruction channel and the boot loader,
// port B serves the CPU data bus. Both ports have req/gnt/rvalid handshakes and a ReadLatency-deep response pipe.
module ram_2p_boot #(
   parameter int    DataWidth   = 32,
   parameter int    Depth       = 1024,
   parameter int    ReadLatency = 1,
   parameter string MemInitFile = ""
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     boot_i,
   input  logic                     cpu_req_i,
   input  logic                     cpu_we_i,
   input  logic [DataWidth/8-1:0]   cpu_be_i,
   input  logic [31:0]              cpu_addr_i,
   input  logic [DataWidth-1:0]     cpu_wdata_i,
   output logic                     cpu_gnt_o,
   output logic                     cpu_rvalid_o,
   output logic [DataWidth-1:0]     cpu_rdata_o,
   output logic                     cpu_err_o,
   input  logic                     boot_req_i,
   input  logic                     boot_we_i,
   input  logic [DataWidth/8-1:0]   boot_be_i,
   input  logic [31:0]              boot_addr_i,
   input  logic [DataWidth-1:0]     boot_wdata_i,
   output logic                     boot_gnt_o,
   output logic                     boot_rvalid_o,
   output logic [DataWidth-1:0]     boot_rdata_o,
   output logic                     boot_err_o,
   input  logic                     b_req_i,
   input  logic                     b_we_i,
   input  logic [DataWidth/8-1:0]   b_be_i,
   input  logic [31:0]              b_addr_i,
   input  logic [DataWidth-1:0]     b_wdata_i,
   output logic                     b_gnt_o,
   output logic                     b_rvalid_o,
   output logic [DataWidth-1:0]     b_rdata_o,
   output logic                     b_err_o
);

   localparam int BW  = DataWidth / 8;
   localparam int OFF = $clog2(BW);
   localparam int AW  = $clog2(Depth);
   localparam int PL  = ReadLatency - 1;

   function automatic logic addr_err(input logic [31:0] addr);
      return (addr[31:OFF+AW] != '0) || (addr[OFF-1:0] != '0);
   endfunction

   logic [DataWidth-1:0] mem_r [Depth];

   logic                 sel_r;
   logic                 a_switch_s, a_req_s, a_we_s, a_gnt_s, a_err_s, a_wr_s, a_busy_s;
   logic [BW-1:0]        a_be_s;
   logic [31:0]          a_addr_s;
   logic [DataWidth-1:0] a_wdata_s;
   logic [AW-1:0]        a_idx_s, b_idx_s;
   logic                 b_err_s, b_wr_s, collide_s;
   logic                 cpu_rvalid_r, boot_rvalid_r, b_rvalid_r;
   logic                 cpu_err_r, boot_err_r, b_err_r;
   logic [DataWidth-1:0] cpu_rdata_r, boot_rdata_r, b_rdata_r;

   logic                 acc_v_s [2];
   logic                 acc_e_s [2];
   logic [DataWidth-1:0] acc_d_s [2];
   logic                 out_v_s [2];
   logic                 out_e_s [2];
   logic [DataWidth-1:0] out_d_s [2];
   logic                 pipe_busy_s [2];

   // Port A request mux: the registered owner selects which channel drives the port
   always_comb begin
      a_switch_s = (boot_i != sel_r);
      if (sel_r) begin
         a_req_s   = boot_req_i;
         a_we_s    = boot_we_i;
         a_be_s    = boot_be_i;
         a_addr_s  = boot_addr_i;
         a_wdata_s = boot_wdata_i;
      end else begin
         a_req_s   = cpu_req_i;
         a_we_s    = cpu_we_i;
         a_be_s    = cpu_be_i;
         a_addr_s  = cpu_addr_i;
         a_wdata_s = cpu_wdata_i;
      end
   end

   // Grant, error decode and same-word write collision (port A wins)
   always_comb begin
      a_gnt_s   = a_req_s && !a_switch_s;
      a_err_s   = addr_err(a_addr_s);
      a_idx_s   = a_addr_s[OFF+AW-1:OFF];
      a_wr_s    = a_gnt_s && a_we_s && !a_err_s;
      b_err_s   = addr_err(b_addr_i);
      b_idx_s   = b_addr_i[OFF+AW-1:OFF];
      collide_s = a_wr_s && b_we_i && !b_err_s && (a_idx_s == b_idx_s);
      b_gnt_o   = b_req_i && !collide_s;
      b_wr_s    = b_gnt_o && b_we_i && !b_err_s;
   end

   assign cpu_gnt_o  = a_gnt_s && !sel_r;
   assign boot_gnt_o = a_gnt_s && sel_r;

   // Read-first access stage: the word is sampled before this cycle's write lands
   always_comb begin
      acc_v_s[0] = a_gnt_s;
      acc_e_s[0] = a_err_s;
      if (a_err_s) begin
         acc_d_s[0] = '0;
      end else begin
         acc_d_s[0] = mem_r[a_idx_s];
      end
      acc_v_s[1] = b_gnt_o;
      acc_e_s[1] = b_err_s;
      if (b_err_s) begin
         acc_d_s[1] = '0;
      end else begin
         acc_d_s[1] = mem_r[b_idx_s];
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      if (PL == 0) begin : g_direct
         assign out_v_s[p]     = acc_v_s[p];
         assign out_e_s[p]     = acc_e_s[p];
         assign out_d_s[p]     = acc_d_s[p];
         assign pipe_busy_s[p] = 1'b0;
      end else begin : g_pipe
         logic [PL-1:0]        v_r;
         logic [PL-1:0]        e_r;
         logic [DataWidth-1:0] d_r [PL];

         // Response delay line; reset discards anything still in flight
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_r <= '0;
               e_r <= '0;
               for (int k = 0; k < PL; k++) begin
                  d_r[k] <= '0;
               end
            end else begin
               v_r[0] <= acc_v_s[p];
               e_r[0] <= acc_e_s[p];
               d_r[0] <= acc_d_s[p];
               for (int k = 1; k < PL; k++) begin
                  v_r[k] <= v_r[k-1];
                  e_r[k] <= e_r[k-1];
                  d_r[k] <= d_r[k-1];
               end
            end
         end

         assign out_v_s[p]     = v_r[PL-1];
         assign out_e_s[p]     = e_r[PL-1];
         assign out_d_s[p]     = d_r[PL-1];
         assign pipe_busy_s[p] = |v_r;
      end
   end

   assign a_busy_s = pipe_busy_s[0] || cpu_rvalid_r || boot_rvalid_r;

   // Owner register follows boot_i only once port A has drained
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_r <= 1'b0;
      end else if (!a_busy_s) begin
         sel_r <= boot_i;
      end
   end

   // Byte-enabled writes from both ports; contents are never reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < BW; i++) begin
         if (a_wr_s && a_be_s[i]) begin
            mem_r[a_idx_s][8*i +: 8] <= a_wdata_s[8*i +: 8];
         end
         if (b_wr_s && b_be_i[i]) begin
            mem_r[b_idx_s][8*i +: 8] <= b_wdata_i[8*i +: 8];
         end
      end
   end

   // Response output registers; rdata/err hold while rvalid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rvalid_r  <= 1'b0;
         boot_rvalid_r <= 1'b0;
         b_rvalid_r    <= 1'b0;
         cpu_err_r     <= 1'b0;
         boot_err_r    <= 1'b0;
         b_err_r       <= 1'b0;
         cpu_rdata_r   <= '0;
         boot_rdata_r  <= '0;
         b_rdata_r     <= '0;
      end else begin
         cpu_rvalid_r  <= out_v_s[0] && !sel_r;
         boot_rvalid_r <= out_v_s[0] && sel_r;
         b_rvalid_r    <= out_v_s[1];
         if (out_v_s[0] && !sel_r) begin
            cpu_err_r   <= out_e_s[0];
            cpu_rdata_r <= out_d_s[0];
         end
         if (out_v_s[0] && sel_r) begin
            boot_err_r   <= out_e_s[0];
            boot_rdata_r <= out_d_s[0];
         end
         if (out_v_s[1]) begin
            b_err_r   <= out_e_s[1];
            b_rdata_r <= out_d_s[1];
         end
      end
   end

   assign cpu_rvalid_o  = cpu_rvalid_r;
   assign cpu_err_o     = cpu_err_r;
   assign cpu_rdata_o   = cpu_rdata_r;
   assign boot_rvalid_o = boot_rvalid_r;
   assign boot_err_o    = boot_err_r;
   assign boot_rdata_o  = boot_rdata_r;
   assign b_rvalid_o    = b_rvalid_r;
   assign b_err_o       = b_err_r;
   assign b_rdata_o     = b_rdata_r;

endmodule
